acc_unit: RTL and testbench
===========================

# acc_unit

Parametrised accumulator register for the datapath; the next generation of the single-register accumulator. It holds one WIDTH-bit accumulator, executes load, clear, ALU and shift operations against an operand in one cycle, and optionally runs a multi-cycle shift-add multiply. It drives condition flags to the controller and uses a valid/ready handshake, so the control unit can stall on long operations.

## Interface
- WIDTH, 16, accumulator and operand width in bits (>= 4)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  operation request
- op_code  in  4  operation select (see Operation)
- operand  in  WIDTH  second operand
- op_ready  out  1  block can accept an op; combinational, equals ~busy
- acc_out  out  WIDTH  accumulator value
- flag_z  out  1  result zero
- flag_n  out  1  result MSB
- flag_c  out  1  carry/borrow/shifted-out bit
- flag_v  out  1  signed overflow
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse, multiply result written

## Operation
- An op is accepted on a rising edge with op_valid && op_ready; otherwise acc_out and the flags hold.
- op_code values:
  - 0 NOP
  - 1 LOAD, acc = operand
  - 2 CLR, acc = 0
  - 3 ADD
  - 4 SUB, acc - operand
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 SHL by 1
  - 9 SHR by 1 (logical)
  - 10 SAR by 1 (arithmetic)
  - 11 MUL
  - 12-15 reserved, treated as NOP
- operand is ignored for CLR and all shifts.
- Arithmetic is modulo 2^WIDTH.
- Flags are updated by every op except NOP and reserved codes:
  - Z and N are taken from the new acc.
  - ADD: C = carry out of the MSB; V = signed overflow.
  - SUB: C = borrow (operand > acc, unsigned); V = signed overflow.
  - SHL: C = old acc[WIDTH-1]. SHR/SAR: C = old acc[0]. V = 0.
  - LOAD, CLR, AND, OR, XOR: C = 0, V = 0.
  - MUL: C = 1 if the upper WIDTH bits of the 2*WIDTH product are nonzero; V = 0.
- MUL FSM, unsigned acc × operand, low WIDTH bits written to acc:
  - IDLE: on accepting MUL, latch multiplicand = acc and multiplier = operand, clear the 2*WIDTH partial product, set count = 0, go to RUN.
  - RUN: each cycle, if multiplier[0], add the multiplicand (shifted by count) into the partial product; shift the multiplier right; count++. When count reaches WIDTH-1 on an edge, write acc and flags and go to IDLE.
- acc_out is not modified during RUN; it shows the old value until the result edge.

## Timing
- Reset values:
  - acc_out = 0
  - flag_z = 1
  - flag_n, flag_c, flag_v = 0
  - busy = 0, done = 0
  - op_ready = 1; FSM in IDLE
- Single-cycle ops: acc_out and the flags are valid immediately after the accepting edge. Back-to-back ops are allowed every cycle.
- MUL accepted on edge E:
  - busy = 1 and op_ready = 0 after E.
  - The result is written on edge E+WIDTH. busy falls and done = 1 for exactly the cycle after E+WIDTH.
  - The next op can be accepted at the earliest on edge E+WIDTH+1.
- op_valid while busy: ignored, not queued. The requester must hold it until op_ready.
- rst mid-MUL aborts immediately: all outputs return to reset values, no done pulse, FSM returns to IDLE.
- MUL with operand 0 or acc 0 still takes WIDTH cycles; there is no early exit.

## Configuration
- ACC_MUL_EN defined: MUL FSM, busy and done are present as specified.
- ACC_MUL_EN undefined: no FSM and no multiplier logic.
  - op_code 11 behaves as NOP; flags are unchanged.
  - busy and done are tied to 0; op_ready is tied to 1.

## Test plan
- Reset, then release: acc_out = 0x0000, flag_z = 1, op_ready = 1. Assert rst asynchronously mid-cycle: outputs clear without a clock edge.
- Overflow and borrow (WIDTH = 16):
  - LOAD 0x7FFF, then ADD 0x0001 -> acc 0x8000, N = 1, V = 1, C = 0.
  - ADD 0x8000 -> acc 0x0000, Z = 1, C = 1, V = 1.
  - SUB 0x0001 -> acc 0xFFFF, C = 1 (borrow), N = 1.
- Shifts:
  - LOAD 0x8001, SHL -> 0x0002, C = 1.
  - LOAD 0x8001, SAR -> 0xC000, C = 1.
  - LOAD 0x8001, SHR -> 0x4000, C = 1.
- MUL result (ACC_MUL_EN): LOAD 0x0012, MUL 0x0034.
  - busy is high for 16 cycles; acc stays 0x0012 until the result edge.
  - Then acc = 0x03A8, C = 0, done pulses exactly 1 cycle.
  - An op_valid held during busy is accepted only after busy falls.
- MUL high half (ACC_MUL_EN): LOAD 0xFFFF, MUL 0x0002 -> acc 0xFFFE, C = 1.
- Abort and compile-out:
  - rst asserted 5 cycles into a MUL -> no done pulse, acc = 0, next op accepted normally.
  - Rebuilt without ACC_MUL_EN: MUL leaves acc and flags unchanged, busy stays 0.

Source files
------------

// File: rtl/acc_unit.sv
// rtl/acc_unit.sv - WIDTH-bit accumulator with ALU/shift ops, flags and optional shift-add multiply (ACC_MUL_EN)
module acc_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] operand,
    output logic             op_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_CLR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SAR  = 4'd10;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [WIDTH:0]   sum, diff;
    logic             accept;

    assign sum  = {1'b0, acc_q} + {1'b0, operand};
    assign diff = {1'b0, acc_q} - {1'b0, operand};

`ifdef ACC_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic {IDLE, RUN} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_next;
    logic [CW-1:0]      count_q, count_d;
    logic               done_q, done_d;

    // Partial product after folding in the current multiplier bit
    assign prod_next = prod_q + (mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q)
                                             : {2*WIDTH{1'b0}});
    assign busy     = (state_q == RUN);
    assign done     = done_q;
`else
    assign busy     = 1'b0;
    assign done     = 1'b0;
`endif

    assign op_ready = ~busy;
    assign accept   = op_valid && op_ready;
    assign acc_out  = acc_q;
    assign flag_z   = z_q;
    assign flag_n   = n_q;
    assign flag_c   = c_q;
    assign flag_v   = v_q;

    // Next accumulator/flags for single-cycle ops and the multiply sequencer
    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        n_d   = n_q;
        c_d   = c_q;
        v_d   = v_q;
`ifdef ACC_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        count_d  = count_q;
        done_d   = 1'b0;
`endif
        if (accept) begin
            case (op_code)
                OP_LOAD: begin acc_d = operand;           c_d = 1'b0;  v_d = 1'b0; end
                OP_CLR:  begin acc_d = '0;                c_d = 1'b0;  v_d = 1'b0; end
                OP_ADD:  begin
                    acc_d = sum[WIDTH-1:0];
                    c_d   = sum[WIDTH];
                    v_d   = (acc_q[WIDTH-1] == operand[WIDTH-1]) &&
                            (sum[WIDTH-1] != acc_q[WIDTH-1]);
                end
                OP_SUB:  begin
                    acc_d = diff[WIDTH-1:0];
                    c_d   = diff[WIDTH];
                    v_d   = (acc_q[WIDTH-1] != operand[WIDTH-1]) &&
                            (diff[WIDTH-1] != acc_q[WIDTH-1]);
                end
                OP_AND:  begin acc_d = acc_q & operand;   c_d = 1'b0;  v_d = 1'b0; end
                OP_OR:   begin acc_d = acc_q | operand;   c_d = 1'b0;  v_d = 1'b0; end
                OP_XOR:  begin acc_d = acc_q ^ operand;   c_d = 1'b0;  v_d = 1'b0; end
                OP_SHL:  begin acc_d = {acc_q[WIDTH-2:0], 1'b0};             c_d = acc_q[WIDTH-1]; v_d = 1'b0; end
                OP_SHR:  begin acc_d = {1'b0, acc_q[WIDTH-1:1]};             c_d = acc_q[0];       v_d = 1'b0; end
                OP_SAR:  begin acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};   c_d = acc_q[0];       v_d = 1'b0; end
`ifdef ACC_MUL_EN
                OP_MUL:  begin
                    mcand_d  = acc_q;
                    mplier_d = operand;
                    prod_d   = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
`endif
                default: ;
            endcase
            z_d = (acc_d == '0);
            n_d = acc_d[WIDTH-1];
`ifdef ACC_MUL_EN
            // MUL defers its flag update to the result edge
            if (op_code == OP_MUL) begin
                z_d = z_q;
                n_d = n_q;
            end
`endif
            // NOP and reserved codes leave everything untouched
            if (op_code == 4'd0 || op_code > 4'd10) begin
                z_d = z_q;
                n_d = n_q;
            end
        end
`ifdef ACC_MUL_EN
        if (state_q == RUN) begin
            prod_d   = prod_next;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
                acc_d   = prod_next[WIDTH-1:0];
                z_d     = (prod_next[WIDTH-1:0] == '0);
                n_d     = prod_next[WIDTH-1];
                c_d     = |prod_next[2*WIDTH-1:WIDTH];
                v_d     = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
`endif
    end

    // Accumulator and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            z_q   <= 1'b1;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            n_q   <= n_d;
            c_q   <= c_d;
            v_q   <= v_d;
        end
    end

`ifdef ACC_MUL_EN
    // Multiply sequencer state and working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end
`endif

endmodule

// File: tb/tb_acc_unit.sv
// tb/tb_acc_unit.sv - directed and random checks of acc_unit against a behavioural model
module tb_acc_unit;
    localparam int W = 16;
`ifdef ACC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [3:0]   op_code;
    logic [W-1:0] operand;
    logic         op_ready;
    logic [W-1:0] acc_out;
    logic         flag_z, flag_n, flag_c, flag_v, busy, done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_acc;
    logic         m_z, m_n, m_c, m_v;

    acc_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .operand(operand),
        .op_ready(op_ready), .acc_out(acc_out), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_z = 1'b1; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    endtask

    // Architectural effect of one op, from plain integer arithmetic
    task automatic model(input logic [3:0] code, input logic [W-1:0] b);
        longint ua, ub, r;
        longint sa, sb;
        logic [W-1:0] a, res;
        a  = m_acc;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        case (code)
            4'd1:  begin res = b;     m_c = 0; m_v = 0; end
            4'd2:  begin res = 0;     m_c = 0; m_v = 0; end
            4'd3:  begin
                r = ua + ub; res = W'(r % 65536); m_c = (r >= 65536);
                r = sa + sb; m_v = (r > 32767) || (r < -32768);
            end
            4'd4:  begin
                r = ua - ub + 65536; res = W'(r % 65536); m_c = (ub > ua);
                r = sa - sb; m_v = (r > 32767) || (r < -32768);
            end
            4'd5:  begin res = a & b; m_c = 0; m_v = 0; end
            4'd6:  begin res = a | b; m_c = 0; m_v = 0; end
            4'd7:  begin res = a ^ b; m_c = 0; m_v = 0; end
            4'd8:  begin res = W'((ua * 2) % 65536);                 m_c = (ua >= 32768); m_v = 0; end
            4'd9:  begin res = W'(ua / 2);                           m_c = ua[0];         m_v = 0; end
            4'd10: begin res = W'(ua / 2 + ((ua >= 32768) ? 32768 : 0)); m_c = ua[0];     m_v = 0; end
            4'd11: begin
                if (!MUL_EN) return;
                r = ua * ub; res = W'(r % 65536); m_c = (r >= 65536); m_v = 0;
            end
            default: return;
        endcase
        m_acc = res;
        m_z   = (res == 0);
        m_n   = (res >= 16'h8000);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_acc"}, 32'(acc_out), 32'(m_acc));
        chk({tag, "_z"},   32'(flag_z),  32'(m_z));
        chk({tag, "_n"},   32'(flag_n),  32'(m_n));
        chk({tag, "_c"},   32'(flag_c),  32'(m_c));
        chk({tag, "_v"},   32'(flag_v),  32'(m_v));
    endtask

    task automatic apply(input string tag, input logic [3:0] code, input logic [W-1:0] b);
        logic [W-1:0] old;
        @(negedge clk);
        op_valid = 1'b1; op_code = code; operand = b;
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 4'd0;
        old = m_acc;
        model(code, b);
`ifdef ACC_MUL_EN
        if (code == 4'd11) begin
            chk({tag, "_busy0"}, 32'(busy), 32'd1);
            chk({tag, "_rdy0"}, 32'(op_ready), 32'd0);
            chk({tag, "_hold0"}, 32'(acc_out), 32'(old));
            for (int k = 1; k < W; k++) begin
                @(posedge clk); #1;
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_hold"}, 32'(acc_out), 32'(old));
                chk({tag, "_nodone"}, 32'(done), 32'd0);
            end
            @(posedge clk); #1;
            chk({tag, "_busyfall"}, 32'(busy), 32'd0);
            chk({tag, "_done"}, 32'(done), 32'd1);
            check_state(tag);
            @(posedge clk); #1;
            chk({tag, "_donefall"}, 32'(done), 32'd0);
            return;
        end
`endif
        check_state(tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"}, 32'(op_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; operand = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_acc", 32'(acc_out), 32'h0);
        chk("rst_z", 32'(flag_z), 32'd1);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // asynchronous reset mid-cycle
        apply("ld1234", 4'd1, 16'h1234);
        @(posedge clk); #2; rst = 1'b1;
        #1;
        model_reset();
        chk("arst_acc", 32'(acc_out), 32'h0);
        chk("arst_z", 32'(flag_z), 32'd1);
        #1; rst = 1'b0;

        // overflow and borrow
        apply("ld7fff", 4'd1, 16'h7FFF);
        apply("add_ovf", 4'd3, 16'h0001);
        chk("add_ovf_k", 32'({acc_out, flag_n, flag_v, flag_c}), 32'({16'h8000, 3'b110}));
        apply("add_wrap", 4'd3, 16'h8000);
        chk("add_wrap_k", 32'({acc_out, flag_z, flag_c, flag_v}), 32'({16'h0000, 3'b111}));
        apply("sub_bor", 4'd4, 16'h0001);
        chk("sub_bor_k", 32'({acc_out, flag_c, flag_n}), 32'({16'hFFFF, 2'b11}));

        // shifts
        apply("ld8001a", 4'd1, 16'h8001);
        apply("shl", 4'd8, 16'hFFFF);
        chk("shl_k", 32'({acc_out, flag_c}), 32'({16'h0002, 1'b1}));
        apply("ld8001b", 4'd1, 16'h8001);
        apply("sar", 4'd10, 16'h0000);
        chk("sar_k", 32'({acc_out, flag_c}), 32'({16'hC000, 1'b1}));
        apply("ld8001c", 4'd1, 16'h8001);
        apply("shr", 4'd9, 16'h5555);
        chk("shr_k", 32'({acc_out, flag_c}), 32'({16'h4000, 1'b1}));

`ifdef ACC_MUL_EN
        // multiply with an op_valid held across busy
        apply("ld12", 4'd1, 16'h0012);
        @(negedge clk);
        op_valid = 1'b1; op_code = 4'd11; operand = 16'h0034;
        @(posedge clk); #1;
        op_code = 4'd3; operand = 16'h0001;
        for (int k = 0; k < W; k++) begin
            chk("mulh_busy", 32'(busy), 32'd1);
            chk("mulh_hold", 32'(acc_out), 32'h0012);
            @(posedge clk); #1;
        end
        model(4'd11, 16'h0034);
        chk("mulh_done", 32'(done), 32'd1);
        chk("mulh_busyfall", 32'(busy), 32'd0);
        chk("mulh_res", 32'({acc_out, flag_c}), 32'({16'h03A8, 1'b0}));
        check_state("mulh");
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 4'd0;
        model(4'd3, 16'h0001);
        chk("mulh_donefall", 32'(done), 32'd0);
        chk("mulh_heldadd", 32'(acc_out), 32'h03A9);
        check_state("heldadd");

        apply("ldffff", 4'd1, 16'hFFFF);
        apply("mul_hi", 4'd11, 16'h0002);
        chk("mul_hi_k", 32'({acc_out, flag_c}), 32'({16'hFFFE, 1'b1}));
        apply("ld0", 4'd2, 16'h1111);
        apply("mul_zero", 4'd11, 16'h1234);

        // reset aborts a multiply
        apply("ld5", 4'd1, 16'h0005);
        @(negedge clk);
        op_valid = 1'b1; op_code = 4'd11; operand = 16'h0007;
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 4'd0;
        repeat (5) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        model_reset();
        chk("abort_acc", 32'(acc_out), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd1);
        #1; rst = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            chk("abort_nodone", 32'(done), 32'd0);
        end
        check_state("abort_after");
        apply("abort_next", 4'd1, 16'hABCD);
`else
        apply("ld_nm", 4'd1, 16'h8000);
        apply("sub_nm", 4'd4, 16'h0001);
        apply("mul_nop", 4'd11, 16'h0003);
        chk("mul_nop_k", 32'({acc_out, flag_v, busy}), 32'({16'h7FFF, 1'b1, 1'b0}));
`endif

        // random ops against the model
        for (int i = 0; i < 300; i++) begin
            apply("rnd", 4'($urandom_range(0, 15)), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound in case a handshake never completes
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
